pn_port_allocator: RTL and testbench

- Sequential output-port allocator that sits directly after the 4-input permutation network in the bufferless (BLESS) router.
- Takes the four age-sorted ranks (original input index plus productive-port vector, ppv) and grants each valid flit one of the four network output ports (N/E/S/W, ppv bit 0..3) in strict rank order.
- Deflects a flit when none of its productive ports is free.
- Registers grants behind a valid/ready handshake and keeps a saturating deflection counter for router statistics.

---
 rtl/pn_port_allocator.sv | 155 +++++++++++++++
 tb/tb_pn_port_allocator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pn_port_allocator.sv
// Output-port allocator for the BLESS router: grants age-ranked flits one of
// four network ports in rank order, deflecting when no productive port is free.
module pn_port_allocator #(
  parameter int unsigned NUM_OUT   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req,
  output logic                   in_ready,
  input  logic [NUM_OUT-1:0]     in_valid,
  input  logic [1:0]             rank0_dir,
  input  logic [1:0]             rank1_dir,
  input  logic [1:0]             rank2_dir,
  input  logic [1:0]             rank3_dir,
  input  logic [NUM_OUT-1:0]     rank0_ppv,
  input  logic [NUM_OUT-1:0]     rank1_ppv,
  input  logic [NUM_OUT-1:0]     rank2_ppv,
  input  logic [NUM_OUT-1:0]     rank3_ppv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NUM_OUT-1:0]   grant_port,
  output logic [NUM_OUT-1:0]     grant_vld,
  output logic [NUM_OUT-1:0]     deflected,
  output logic                   perm_err,
  input  logic                   cnt_clear,
  output logic [CNT_WIDTH-1:0]   defl_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 load;
  logic [1:0]           dir [NUM_OUT];
  logic [NUM_OUT-1:0]   ppv [NUM_OUT];
  logic [1:0]           sel_port [NUM_OUT];
  logic [2*NUM_OUT-1:0] alloc_port;
  logic [NUM_OUT-1:0]   alloc_vld;
  logic [NUM_OUT-1:0]   alloc_defl;
  logic                 dup_dir;
  logic [2:0]           defl_pop;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH+2:0] cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  function automatic logic [1:0] lowest_set(input logic [NUM_OUT-1:0] v);
    logic found;
    lowest_set = 2'd0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (v[i] && !found) begin
        lowest_set = i[1:0];
        found      = 1'b1;
      end
    end
  endfunction

  assign in_ready = ~out_valid | out_ready;
  assign load     = in_req & in_ready;

  always_comb begin
    dir[0] = rank0_dir;
    dir[1] = rank1_dir;
    dir[2] = rank2_dir;
    dir[3] = rank3_dir;
    ppv[0] = rank0_ppv;
    ppv[1] = rank1_ppv;
    ppv[2] = rank2_ppv;
    ppv[3] = rank3_ppv;
  end

  // Rank-ordered allocation; a duplicated dir simply overwrites the earlier
  // grant for that index while the earlier port stays consumed.
  always_comb begin
    logic [NUM_OUT-1:0] free;
    logic [NUM_OUT-1:0] hit;
    logic [1:0]         d;
    logic [1:0]         p;
    free       = '1;
    alloc_vld  = '0;
    alloc_defl = '0;
    hit        = '0;
    d          = 2'd0;
    p          = 2'd0;
    for (int unsigned i = 0; i < NUM_OUT; i++) sel_port[i] = 2'd0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      d = dir[k];
      if (in_valid[d]) begin
        hit = ppv[k] & free;
        if (hit != '0) begin
          p             = lowest_set(hit);
          alloc_defl[d] = 1'b0;
        end else begin
          p             = lowest_set(free);
          alloc_defl[d] = 1'b1;
        end
        sel_port[d]  = p;
        alloc_vld[d] = 1'b1;
        free[p]      = 1'b0;
      end
    end
  end

  always_comb begin
    alloc_port = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) alloc_port[2*i +: 2] = sel_port[i];
  end

  always_comb begin
    dup_dir = 1'b0;
    for (int unsigned a = 0; a < NUM_OUT; a++) begin
      for (int unsigned b = a + 1; b < NUM_OUT; b++) begin
        if (dir[a] == dir[b]) dup_dir = 1'b1;
      end
    end
  end

  always_comb begin
    defl_pop = 3'd0;
    for (int unsigned i = 0; i < NUM_OUT; i++) defl_pop = defl_pop + {2'b00, alloc_defl[i]};
  end

  // Clear applies before this cycle's load so a same-cycle load is still counted.
  always_comb begin
    cnt_base = cnt_clear ? '0 : defl_count;
    cnt_sum  = {3'b000, cnt_base} + {{CNT_WIDTH{1'b0}}, defl_pop};
    cnt_next = cnt_base;
    if (load) begin
      if (cnt_sum > {3'b000, CNT_MAX}) cnt_next = CNT_MAX;
      else                             cnt_next = cnt_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      grant_port <= '0;
      grant_vld  <= '0;
      deflected  <= '0;
      perm_err   <= 1'b0;
      defl_count <= '0;
    end else begin
      defl_count <= cnt_next;
      if (load) begin
        out_valid  <= 1'b1;
        grant_port <= alloc_port;
        grant_vld  <= alloc_vld;
        deflected  <= alloc_defl;
        if (dup_dir) perm_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pn_port_allocator.sv
// Directed bench for pn_port_allocator with a 4-bit deflection counter so
// saturation is reachable with a handful of loads.
module tb_pn_port_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_req;
  logic       in_ready;
  logic [3:0] in_valid;
  logic [1:0] rank0_dir, rank1_dir, rank2_dir, rank3_dir;
  logic [3:0] rank0_ppv, rank1_ppv, rank2_ppv, rank3_ppv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] grant_port;
  logic [3:0] grant_vld;
  logic [3:0] deflected;
  logic       perm_err;
  logic       cnt_clear;
  logic [3:0] defl_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pn_port_allocator #(.NUM_OUT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ready(in_ready),
    .in_valid(in_valid),
    .rank0_dir(rank0_dir), .rank1_dir(rank1_dir), .rank2_dir(rank2_dir), .rank3_dir(rank3_dir),
    .rank0_ppv(rank0_ppv), .rank1_ppv(rank1_ppv), .rank2_ppv(rank2_ppv), .rank3_ppv(rank3_ppv),
    .out_valid(out_valid), .out_ready(out_ready), .grant_port(grant_port),
    .grant_vld(grant_vld), .deflected(deflected), .perm_err(perm_err),
    .cnt_clear(cnt_clear), .defl_count(defl_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ranks(input logic [3:0] v,
                       input logic [1:0] d0, input logic [1:0] d1,
                       input logic [1:0] d2, input logic [1:0] d3,
                       input logic [3:0] p0, input logic [3:0] p1,
                       input logic [3:0] p2, input logic [3:0] p3);
    in_valid  = v;
    rank0_dir = d0; rank1_dir = d1; rank2_dir = d2; rank3_dir = d3;
    rank0_ppv = p0; rank1_ppv = p1; rank2_ppv = p2; rank3_ppv = p3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic result(input string tag, input logic [7:0] gp, input logic [3:0] gv,
                        input logic [3:0] df, input logic [3:0] cnt);
    check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    check({tag, "_port"},  {8'd0, grant_port}, {8'd0, gp});
    check({tag, "_vld"},   {12'd0, grant_vld}, {12'd0, gv});
    check({tag, "_defl"},  {12'd0, deflected}, {12'd0, df});
    check({tag, "_cnt"},   {12'd0, defl_count}, {12'd0, cnt});
  endtask

  initial begin
    reset = 1'b1; in_req = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    ranks(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_port",  {8'd0, grant_port}, 16'd0);
    check("rst_vld",   {12'd0, grant_vld}, 16'd0);
    check("rst_defl",  {12'd0, deflected}, 16'd0);
    check("rst_perm",  {15'd0, perm_err}, 16'd0);
    check("rst_cnt",   {12'd0, defl_count}, 16'd0);
    check("rst_ready", {15'd0, in_ready}, 16'd1);

    // Straight-through: every flit gets its own productive port.
    ranks(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    in_req = 1'b1;
    tick();
    result("setup", 8'b11_10_01_00, 4'b1111, 4'b0000, 4'd0);
    in_req = 1'b0;
    tick();
    check("drain_valid", {15'd0, out_valid}, 16'd0);

    // All want port 0: oldest wins it, the rest deflect in rank order.
    ranks(4'b1111, 2'd2, 2'd0, 2'd3, 2'd1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    in_req = 1'b1;
    tick();
    result("conflict", 8'b10_00_11_01, 4'b1111, 4'b1011, 4'd3);

    // Back-to-back partial load, then stall with a pending request.
    ranks(4'b0101, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    tick();
    result("partial", 8'b00_00_00_10, 4'b0101, 4'b0100, 4'd4);
    out_ready = 1'b0;
    ranks(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", {15'd0, in_ready}, 16'd0);
      result("stall", 8'b00_00_00_10, 4'b0101, 4'b0100, 4'd4);
    end
    out_ready = 1'b1;
    #1 check("unstall_ready", {15'd0, in_ready}, 16'd1);
    tick();
    result("after_stall", 8'b11_10_01_00, 4'b1111, 4'b0000, 4'd4);

    // Duplicate dir: rank1 overwrites input 1, input 0 never granted.
    ranks(4'b1111, 2'd1, 2'd1, 2'd2, 2'd3, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    tick();
    result("dup", 8'b11_10_01_00, 4'b1110, 4'b0000, 4'd4);
    check("dup_perm", {15'd0, perm_err}, 16'd1);
    ranks(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    tick();
    check("perm_sticky", {15'd0, perm_err}, 16'd1);
    check("clean_cnt", {12'd0, defl_count}, 16'd4);

    // Climb to 14, then saturate at 15.
    ranks(4'b1111, 2'd2, 2'd0, 2'd3, 2'd1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    tick(); check("cnt7",  {12'd0, defl_count}, 16'd7);
    tick(); check("cnt10", {12'd0, defl_count}, 16'd10);
    tick(); check("cnt13", {12'd0, defl_count}, 16'd13);
    ranks(4'b0101, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    tick(); check("cnt14", {12'd0, defl_count}, 16'd14);
    ranks(4'b1111, 2'd2, 2'd0, 2'd3, 2'd1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    tick(); check("cnt_sat", {12'd0, defl_count}, 16'd15);
    tick(); check("cnt_sat_hold", {12'd0, defl_count}, 16'd15);

    // Clear and a 2-deflection load in the same cycle.
    ranks(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0001, 4'b0001, 4'b0001, 4'b1000);
    cnt_clear = 1'b1;
    tick();
    result("clr_load", 8'b11_10_01_00, 4'b1111, 4'b0110, 4'd2);
    in_req = 1'b0;
    tick();
    check("clr_only_cnt", {12'd0, defl_count}, 16'd0);
    check("clr_only_valid", {15'd0, out_valid}, 16'd0);
    cnt_clear = 1'b0;

    // Reset while a result is held.
    in_req = 1'b1;
    tick();
    check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    in_req = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_port",  {8'd0, grant_port}, 16'd0);
    check("mid_rst_perm",  {15'd0, perm_err}, 16'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {15'd0, in_ready}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
